// File: rtl/bus_uart_tx.sv
// Write-only 8N1 UART transmitter on the ControlUnit output bus.
// Bytes written to the data register are queued in a small FIFO; a full FIFO drops and counts writes.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0800,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bus_address_valid,
  input  logic [31:0]                   bus_address_payload,
  input  logic                          bus_data_valid,
  input  logic [31:0]                   bus_data_payload,
  output logic                          io_uart_tx,
  output logic                          io_busy,
  output logic [$clog2(FIFO_DEPTH):0]   io_fifo_level,
  output logic [7:0]                    io_drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            tx;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [7:0]      drop;

  logic            wr_data;
  logic            wr_ctrl;
  logic            empty;
  logic            full;
  logic            bit_end;
  logic            pop;
  logic            push;
  logic            unused_bits;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wr_data = bus_address_valid && (bus_address_payload == BASE_ADDRESS);
  assign wr_ctrl = bus_address_valid && (bus_address_payload == BASE_ADDRESS + 32'd4);
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  // The end of a stop bit pops directly so consecutive frames have no idle gap.
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push = wr_data && (!full || pop);

  assign unused_bits = ^{bus_data_valid, bus_data_payload[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      drop   <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (wr_data && !push)
        drop <= sat_inc(drop);
      else if (wr_ctrl && bus_data_payload[0])
        drop <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_data_payload[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign io_uart_tx    = tx;
  assign io_busy       = (state != IDLE) || !empty;
  assign io_fifo_level = level;
  assign io_drop_count = drop;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: frame-level reference model checked every cycle,
// a line receiver that decodes the serial output, and directed literal checks.
module tb_bus_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_address_valid;
  logic [31:0] bus_address_payload;
  logic        bus_data_valid;
  logic [31:0] bus_data_payload;
  logic        io_uart_tx;
  logic        io_busy;
  logic [3:0]  io_fifo_level;
  logic [7:0]  io_drop_count;

  int total = 0;
  int bad   = 0;

  bus_uart_tx #(.BASE_ADDRESS(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus_address_valid(bus_address_valid),
    .bus_address_payload(bus_address_payload),
    .bus_data_valid(bus_data_valid),
    .bus_data_payload(bus_data_payload),
    .io_uart_tx(io_uart_tx),
    .io_busy(io_busy),
    .io_fifo_level(io_fifo_level),
    .io_drop_count(io_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "current frame and cycle position within it".
  logic [7:0] mq[$];
  logic [9:0] m_frame;
  bit         m_active = 0;
  int         m_t = 0;
  int         m_drop = 0;
  bit         m_pop;
  bit         cmp_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_active = 0;
      m_t      = 0;
      m_drop   = 0;
    end else begin
      m_pop = (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) m_active = 0;
      end
      if (m_pop) begin
        m_frame  = {1'b1, mq.pop_front(), 1'b0};
        m_active = 1;
        m_t      = 0;
      end
      if (bus_address_valid && bus_address_payload == BASE) begin
        if (mq.size() < DEPTH) mq.push_back(bus_data_payload[7:0]);
        else if (m_drop < 255) m_drop++;
      end else if (bus_address_valid && bus_address_payload == BASE + 32'd4 && bus_data_payload[0]) begin
        m_drop = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tx", io_uart_tx, m_active ? m_frame[m_t / CPB] : 1'b1);
      chk("m_busy", io_busy, (m_active || mq.size() != 0) ? 1 : 0);
      chk("m_level", io_fifo_level, mq.size());
      chk("m_drop", io_drop_count, m_drop);
    end
  end

  // Line receiver sampling mid-bit, independent of the model.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  int         rx_idx;
  int         peak = 0;

  always @(negedge clk) begin
    if (io_fifo_level > peak) peak = io_fifo_level;
    if (reset) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (io_uart_tx === 1'b0) begin
        rx_busy = 1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > CPB && rx_cnt % CPB == CPB / 2) begin
        rx_idx = rx_cnt / CPB - 1;
        if (rx_idx < 8) begin
          rx_sh[rx_idx] = io_uart_tx;
        end else begin
          chk("stop_bit", io_uart_tx, 1);
          rx_q.push_back(rx_sh);
          rx_busy = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic v, input logic [31:0] a, input logic [31:0] d);
    tick();
    bus_address_valid   = v;
    bus_data_valid      = v;
    bus_address_payload = a;
    bus_data_payload    = d;
    tick();
    bus_address_valid = 0;
    bus_data_valid    = 0;
  endtask

  task automatic burst(input int n, input logic [31:0] a, input logic [31:0] start);
    tick();
    for (int i = 0; i < n; i++) begin
      bus_address_valid   = 1;
      bus_data_valid      = 1;
      bus_address_payload = a;
      bus_data_payload    = start + i;
      tick();
    end
    bus_address_valid = 0;
    bus_data_valid    = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (io_busy && n < limit) begin
      n++;
      @(negedge clk);
    end
    chk("idle_within_bound", io_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset               = 1;
    bus_address_valid   = 1;
    bus_data_valid      = 1;
    bus_address_payload = BASE;
    bus_data_payload    = 32'h5A;

    // Reset held 3 cycles with writes active.
    @(posedge clk);
    #1 cmp_en = 1;
    tick();
    tick();
    reset             = 0;
    bus_address_valid = 0;
    bus_data_valid    = 0;
    @(negedge clk);
    chk("rst_tx", io_uart_tx, 1);
    chk("rst_busy", io_busy, 0);
    chk("rst_level", io_fifo_level, 0);
    chk("rst_drop", io_drop_count, 0);
    repeat (20) @(negedge clk);
    chk("rst_no_frame", rx_q.size(), 0);

    // Single byte 0x55: start bit 2 cycles after the write, busy for one frame.
    wr(1, BASE, 32'h55);
    @(negedge clk);
    chk("single_tx_before_pop", io_uart_tx, 1);
    chk("single_level", io_fifo_level, 1);
    tick();
    @(negedge clk);
    chk("single_start_bit", io_uart_tx, 0);
    cnt = 0;
    while (io_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("single_busy_len", cnt, 40);
    chk("single_rx_n", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("single_rx_byte", rx_q[0], 8'h55);
    rx_q.delete();

    // Overflow: 10 consecutive writes, the tenth is dropped.
    peak = 0;
    burst(10, BASE, 32'h01);
    @(negedge clk);
    chk("ovf_drop", io_drop_count, 1);
    wait_idle(1000);
    chk("ovf_peak", peak, 8);
    chk("ovf_rx_n", rx_q.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rx_q.size()) chk("ovf_rx_byte", rx_q[i], i + 1);
    rx_q.delete();

    // Decode: only an exact, strobed data address may push.
    wr(1, 32'h0000_0400, 32'h11);
    wr(1, 32'h0000_0801, 32'h22);
    wr(1, 32'h0000_1800, 32'h33);
    wr(0, BASE, 32'h44);
    @(negedge clk);
    chk("dec_level", io_fifo_level, 0);
    chk("dec_tx", io_uart_tx, 1);
    chk("dec_busy", io_busy, 0);
    repeat (10) @(negedge clk);
    chk("dec_no_frame", rx_q.size(), 0);

    // Drop counter saturation and clear.
    burst(330, BASE, 32'h0);
    @(negedge clk);
    chk("cnt_sat", io_drop_count, 255);
    wr(1, BASE + 32'd4, 32'h2);
    @(negedge clk);
    chk("cnt_clear_bit1", io_drop_count, 255);
    wr(1, BASE + 32'd4, 32'h1);
    @(negedge clk);
    chk("cnt_clear", io_drop_count, 0);
    wait_idle(2000);
    rx_q.delete();

    // Reset mid-frame during data bit 3 of 0xA1 with four bytes still queued.
    burst(5, BASE, 32'hA1);
    @(negedge clk);
    chk("mid_level", io_fifo_level, 4);
    repeat (13) tick();
    @(negedge clk);
    chk("mid_bit3", io_uart_tx, 0);
    reset = 1;
    tick();
    @(negedge clk);
    chk("mid_rst_tx", io_uart_tx, 1);
    chk("mid_rst_level", io_fifo_level, 0);
    tick();
    reset = 0;
    repeat (5) @(negedge clk);
    rx_q.delete();
    wr(1, BASE, 32'h3C);
    wait_idle(200);
    chk("mid_rx_n", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("mid_rx_byte", rx_q[0], 8'h3C);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
